// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and sizes for the PWM register scheduler
package synth_pkg;
    localparam int SYNTH_NUM_CH = 8;
    localparam int SYNTH_DUTY_W = 16;

    typedef logic [$clog2(SYNTH_NUM_CH)-1:0] ch_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ARMED = 2'd2
    } sched_state_e;

    typedef struct packed {
        ch_idx_t                 ch;
        logic [SYNTH_DUTY_W-1:0] data;
    } pwm_wr_req_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count; caller never pushes when full or pops when empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
endmodule

// File: rtl/synth_top.sv
// rtl/synth_top.sv - synthesis wrapper exposing each live duty register as its own port
module synth_top
    import synth_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  ch_idx_t                 wr_ch,
    input  logic [SYNTH_DUTY_W-1:0] wr_data,
    input  logic                    frame_tick,
    input  logic                    bypass,
    input  logic                    freeze,
    output logic [SYNTH_DUTY_W-1:0] p0,
    output logic [SYNTH_DUTY_W-1:0] p1,
    output logic [SYNTH_DUTY_W-1:0] p2,
    output logic [SYNTH_DUTY_W-1:0] p3,
    output logic [SYNTH_DUTY_W-1:0] p4,
    output logic [SYNTH_DUTY_W-1:0] p5,
    output logic [SYNTH_DUTY_W-1:0] p6,
    output logic [SYNTH_DUTY_W-1:0] p7,
    output logic                    pending,
    output logic [2:0]              fifo_count,
    output sched_state_e            state
);
    logic [SYNTH_NUM_CH*SYNTH_DUTY_W-1:0] regs;

    pwm_reg_scheduler #(
        .NUM_CH     (SYNTH_NUM_CH),
        .DATA_W     (SYNTH_DUTY_W),
        .FIFO_DEPTH (4)
    ) u_sched (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .frame_tick (frame_tick),
        .bypass     (bypass),
        .freeze     (freeze),
        .pwm_regs   (regs),
        .pending    (pending),
        .fifo_count (fifo_count),
        .state      (state)
    );

    assign {p7, p6, p5, p4, p3, p2, p1, p0} = regs;
endmodule

// File: rtl/pwm_reg_scheduler.sv
// rtl/pwm_reg_scheduler.sv - queues duty writes into shadows and commits them to live registers on frame ticks
module pwm_reg_scheduler
    import synth_pkg::*;
#(
    parameter  int NUM_CH     = 8,
    parameter  int DATA_W     = 16,
    parameter  int FIFO_DEPTH = 4,
    localparam int CH_W       = $clog2(NUM_CH),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     frame_tick,
    input  logic                     bypass,
    input  logic                     freeze,
    output logic [NUM_CH*DATA_W-1:0] pwm_regs,
    output logic                     pending,
    output logic [CNT_W-1:0]         fifo_count,
    output sched_state_e             state
);
    logic                   push;
    logic                   pop;
    logic                   commit;
    logic [CH_W+DATA_W-1:0] head;
    logic [CH_W-1:0]        head_ch;
    logic [DATA_W-1:0]      head_data;
    logic [CNT_W-1:0]       count_next;
    logic [DATA_W-1:0]      live   [NUM_CH];
    logic [DATA_W-1:0]      shadow [NUM_CH];
    logic [NUM_CH-1:0]      dirty;
    logic [NUM_CH-1:0]      dirty_next;
    sched_state_e           state_next;

    assign wr_ready  = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign push      = wr_valid && wr_ready;
    assign pop       = (fifo_count != '0);
    assign commit    = frame_tick && !freeze;
    assign head_ch   = head[CH_W+DATA_W-1:DATA_W];
    assign head_data = head[DATA_W-1:0];

    sync_fifo #(
        .WIDTH (CH_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({wr_ch, wr_data}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count)
    );

    // A commit drains every dirty bit; a same-edge staged pop re-arms its channel
    always_comb begin
        dirty_next = dirty;
        if (commit) dirty_next = '0;
        if (pop && !bypass) dirty_next[head_ch] = 1'b1;
    end

    // Bypass pops are applied after the commit loop so the newest value wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                live[k]   <= '0;
                shadow[k] <= '0;
            end
            dirty <= '0;
        end else begin
            dirty <= dirty_next;
            if (commit) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (dirty[k]) live[k] <= shadow[k];
                end
            end
            if (pop) begin
                shadow[head_ch] <= head_data;
                if (bypass) live[head_ch] <= head_data;
            end
        end
    end

    assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        state_next = IDLE;
        if (count_next != '0)      state_next = DRAIN;
        else if (dirty_next != '0) state_next = ARMED;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        pwm_regs = '0;
        for (int k = 0; k < NUM_CH; k++) pwm_regs[k*DATA_W +: DATA_W] = live[k];
    end

    assign pending = |dirty;
endmodule

// File: tb/tb_pwm_reg_scheduler.sv
// tb/tb_pwm_reg_scheduler.sv - self-checking bench with a queue-based reference model
module tb_pwm_reg_scheduler;
    import synth_pkg::*;

    localparam int NCH = 8;
    localparam int DW  = 16;
    localparam int DEP = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_valid;
    logic            wr_ready;
    logic [2:0]      wr_ch;
    logic [DW-1:0]   wr_data;
    logic            frame_tick;
    logic            bypass;
    logic            freeze;
    logic [NCH*DW-1:0] pwm_regs;
    logic            pending;
    logic [2:0]      fifo_count;
    sched_state_e    state;

    int checks = 0;
    int errors = 0;

    typedef struct { int ch; logic [DW-1:0] data; } req_t;
    req_t          q[$];
    logic [DW-1:0] live_m   [NCH];
    logic [DW-1:0] shadow_m [NCH];
    bit            dirty_m  [NCH];

    pwm_reg_scheduler #(.NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(DEP)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .frame_tick (frame_tick),
        .bypass     (bypass),
        .freeze     (freeze),
        .pwm_regs   (pwm_regs),
        .pending    (pending),
        .fifo_count (fifo_count),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < NCH; k++) begin
            live_m[k] = '0; shadow_m[k] = '0; dirty_m[k] = 0;
        end
    endtask

    // One clock edge of the reference: commit from old shadows, then pop, then push
    task automatic cyc();
        bit   do_push;
        bit   do_pop;
        req_t r;
        do_push = wr_valid && (q.size() != DEP);
        do_pop  = (q.size() != 0);
        if (frame_tick && !freeze)
            for (int k = 0; k < NCH; k++)
                if (dirty_m[k]) begin live_m[k] = shadow_m[k]; dirty_m[k] = 0; end
        if (do_pop) begin
            r = q.pop_front();
            shadow_m[r.ch] = r.data;
            if (bypass) live_m[r.ch] = r.data;
            else        dirty_m[r.ch] = 1;
        end
        if (do_push) begin
            r.ch = int'(wr_ch); r.data = wr_data;
            q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] chan(input int k);
        return pwm_regs[k*DW +: DW];
    endfunction

    task automatic test_reset();
        reset = 1'b0; wr_valid = 1'b1; wr_ch = 3'd5; wr_data = 16'h5555;
        frame_tick = 1'b1; bypass = 1'b0; freeze = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        wr_valid = 1'b0; frame_tick = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (pwm_regs !== '0) begin errors++; $display("FAIL reset_pwm_regs got %h want 0", pwm_regs); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count got %0d want 0", fifo_count); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", pending); end
        checks++; if (state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", state); end
    endtask

    task automatic test_commit_timing();
        wr_valid = 1'b1; wr_ch = 3'd3; wr_data = 16'h1234;
        cyc();
        wr_valid = 1'b0;
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL commit_pending_N got %b want 0", pending); end
        for (int i = 1; i <= 4; i++) begin
            cyc();
            checks++; if (chan(3) !== 16'h0) begin errors++; $display("FAIL commit_early_ch3 edge N+%0d got %h want 0", i, chan(3)); end
            checks++; if (pending !== 1'b1) begin errors++; $display("FAIL commit_pending edge N+%0d got %b want 1", i, pending); end
        end
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        checks++; if (chan(3) !== 16'h1234) begin errors++; $display("FAIL commit_ch3 got %h want 1234", chan(3)); end
        checks++; if ((pwm_regs & ~({NCH*DW{1'b0}} | (128'hFFFF << 48))) !== '0) begin errors++; $display("FAIL commit_others got %h want 0", pwm_regs); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL commit_pending_fall got %b want 0", pending); end
    endtask

    task automatic test_back_to_back_freeze();
        int            chs [5];
        logic [DW-1:0] vals [5];
        chs  = '{1, 2, 1, 5, 2};
        vals = '{16'h1111, 16'h2222, 16'h3333, 16'h5555, 16'h6666};
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_ch = 3'(chs[i]); wr_data = vals[i];
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready write %0d got %b want 1", i, wr_ready); end
            cyc();
            checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL b2b_count write %0d got %0d want 1", i, fifo_count); end
        end
        wr_valid = 1'b0;
        repeat (2) cyc();
        freeze = 1'b1; frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        checks++; if (chan(1) !== 16'h0 || chan(2) !== 16'h0 || chan(5) !== 16'h0) begin errors++; $display("FAIL freeze_no_commit got %h want chans 1,2,5 = 0", pwm_regs); end
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL freeze_pending got %b want 1", pending); end
        freeze = 1'b0;
        cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        checks++; if (chan(1) !== 16'h3333) begin errors++; $display("FAIL lastwins_ch1 got %h want 3333", chan(1)); end
        checks++; if (chan(2) !== 16'h6666) begin errors++; $display("FAIL lastwins_ch2 got %h want 6666", chan(2)); end
        checks++; if (chan(5) !== 16'h5555) begin errors++; $display("FAIL lastwins_ch5 got %h want 5555", chan(5)); end
        checks++; if (chan(3) !== 16'h1234) begin errors++; $display("FAIL lastwins_ch3 got %h want 1234", chan(3)); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL lastwins_pending got %b want 0", pending); end
    endtask

    task automatic test_collision();
        wr_valid = 1'b1; wr_ch = 3'd0; wr_data = 16'hAAAA;
        cyc();
        wr_data = 16'hBBBB;
        cyc();
        wr_valid = 1'b0; frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        checks++; if (chan(0) !== 16'hAAAA) begin errors++; $display("FAIL collide_first got %h want aaaa", chan(0)); end
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL collide_pending got %b want 1", pending); end
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        checks++; if (chan(0) !== 16'hBBBB) begin errors++; $display("FAIL collide_second got %h want bbbb", chan(0)); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL collide_pending_fall got %b want 0", pending); end
    endtask

    task automatic test_bypass();
        bypass = 1'b1;
        wr_valid = 1'b1; wr_ch = 3'd7; wr_data = 16'hFFFF;
        cyc();
        wr_valid = 1'b0;
        checks++; if (chan(7) !== 16'h0) begin errors++; $display("FAIL bypass_early got %h want 0", chan(7)); end
        cyc();
        checks++; if (chan(7) !== 16'hFFFF) begin errors++; $display("FAIL bypass_ch7 got %h want ffff", chan(7)); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL bypass_pending got %b want 0", pending); end
        bypass = 1'b0;
    endtask

    task automatic test_async_reset();
        wr_valid = 1'b1; wr_ch = 3'd4; wr_data = 16'h4444;
        cyc();
        wr_ch = 3'd6; wr_data = 16'h6666;
        cyc();
        wr_ch = 3'd2; wr_data = 16'h2020;
        cyc();
        wr_valid = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (pwm_regs !== '0) begin errors++; $display("FAIL areset_pwm got %h want 0", pwm_regs); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL areset_pending got %b want 0", pending); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL areset_count got %0d want 0", fifo_count); end
        @(posedge clk); #1;
        reset = 1'b1;
        cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        checks++; if (pwm_regs !== '0) begin errors++; $display("FAIL areset_tick got %h want 0", pwm_regs); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL areset_tick_pending got %b want 0", pending); end
    endtask

    task automatic test_random();
        logic [NCH*DW-1:0] exp_regs;
        bit                any_dirty;
        sched_state_e      exp_state;
        for (int n = 0; n < 400; n++) begin
            if (!(wr_valid && !wr_ready)) begin
                wr_valid = ($urandom_range(0, 2) != 0);
                wr_ch    = 3'($urandom_range(0, NCH - 1));
                wr_data  = 16'($urandom);
            end
            frame_tick = ($urandom_range(0, 3) == 0);
            freeze     = ($urandom_range(0, 3) == 0);
            bypass     = ($urandom_range(0, 7) == 0);
            cyc();
            any_dirty = 0;
            for (int k = 0; k < NCH; k++) begin
                exp_regs[k*DW +: DW] = live_m[k];
                any_dirty |= dirty_m[k];
            end
            exp_state = (q.size() != 0) ? DRAIN : (any_dirty ? ARMED : IDLE);
            checks++; if (pwm_regs !== exp_regs) begin errors++; $display("FAIL rand_pwm cycle %0d got %h want %h", n, pwm_regs, exp_regs); end
            checks++; if (pending !== any_dirty) begin errors++; $display("FAIL rand_pending cycle %0d got %b want %b", n, pending, any_dirty); end
            checks++; if (fifo_count !== 3'(q.size())) begin errors++; $display("FAIL rand_count cycle %0d got %0d want %0d", n, fifo_count, q.size()); end
            checks++; if (wr_ready !== (q.size() != DEP)) begin errors++; $display("FAIL rand_wr_ready cycle %0d got %b want %b", n, wr_ready, q.size() != DEP); end
            checks++; if (state !== exp_state) begin errors++; $display("FAIL rand_state cycle %0d got %0d want %0d", n, state, exp_state); end
        end
        wr_valid = 1'b0; frame_tick = 1'b0; freeze = 1'b0; bypass = 1'b0;
    endtask

    initial begin
        test_reset();
        test_commit_timing();
        test_back_to_back_freeze();
        test_collision();
        test_bypass();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
